// File: rtl/mips_defs.sv
// Shared MIPS definitions: multiply/divide opcodes, default latencies and MDU state type.
// The hazard unit and decoder import the same encodings.
package mips_defs;

    localparam logic [2:0] MDOP_NONE  = 3'b000;
    localparam logic [2:0] MDOP_MULT  = 3'b001;
    localparam logic [2:0] MDOP_MULTU = 3'b010;
    localparam logic [2:0] MDOP_DIV   = 3'b011;
    localparam logic [2:0] MDOP_DIVU  = 3'b100;
    localparam logic [2:0] MDOP_MTHI  = 3'b101;
    localparam logic [2:0] MDOP_MTLO  = 3'b110;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit multiply/divide datapath; flags divide-by-zero so the
// top level can suppress the HI/LO write.
module mdu_core
    import mips_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0]        prod;
    logic [31:0]        divisor;
    logic signed [31:0] sa;
    logic signed [31:0] sd;
    logic               sdiv_ovf;

    // Divisor is forced to 1 on zero so the divider never produces X.
    assign divisor  = (b == 32'd0) ? 32'd1 : b;
    assign sa       = $signed(a);
    assign sd       = $signed(divisor);
    assign sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        prod     = 64'd0;
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (op)
            MDOP_MULT: begin
                prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {res_hi, res_lo} = prod;
            end
            MDOP_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                {res_hi, res_lo} = prod;
            end
            MDOP_DIV: begin
                div_zero = (b == 32'd0);
                if (sdiv_ovf) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = sa / sd;
                    res_hi = sa % sd;
                end
            end
            MDOP_DIVU: begin
                div_zero = (b == 32'd0);
                res_lo   = a / divisor;
                res_hi   = a % divisor;
            end
            default: begin
                prod = 64'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: holds architectural HI/LO and models the
// multi-cycle mult/div latency with a busy countdown.
module mdu
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       temp_hi_reg, temp_lo_reg;
    logic              temp_ok_reg;
    logic [31:0]       hi_reg, lo_reg;

    logic [31:0]       core_hi, core_lo;
    logic              core_div_zero;
    logic              accept, launch, last, done;

    mdu_core u_core (
        .a        (A),
        .b        (B),
        .op       (MDOp),
        .res_hi   (core_hi),
        .res_lo   (core_lo),
        .div_zero (core_div_zero)
    );

    // Cancel beats Start in IDLE and beats completion on the final RUN cycle.
    assign accept = Start && !Cancel && (state_reg == MDU_IDLE);
    assign launch = accept && is_muldiv(MDOp);
    assign last   = (cnt_reg == CNT_W'(1));
    assign done   = (state_reg == MDU_RUN) && !Cancel && last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= MDU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MDU_IDLE: if (launch) state_next = MDU_RUN;
            MDU_RUN:  if (Cancel || last) state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_reg == MDU_RUN);
        HI   = hi_reg;
        LO   = lo_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg     <= '0;
            temp_hi_reg <= 32'd0;
            temp_lo_reg <= 32'd0;
            temp_ok_reg <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            if (launch) begin
                cnt_reg     <= is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                temp_hi_reg <= core_hi;
                temp_lo_reg <= core_lo;
                temp_ok_reg <= !core_div_zero;
            end else if (state_reg == MDU_RUN) begin
                cnt_reg <= Cancel ? '0 : cnt_reg - CNT_W'(1);
            end

            if (done && temp_ok_reg) begin
                hi_reg <= temp_hi_reg;
                lo_reg <= temp_lo_reg;
            end else if (accept && (MDOp == MDOP_MTHI)) begin
                hi_reg <= A;
            end else if (accept && (MDOp == MDOP_MTLO)) begin
                lo_reg <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed plan steps plus randomized ops against
// an arithmetic reference model of HI/LO and the busy window.
module tb_mdu;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] A, B;
    logic [2:0]  MDOp;
    logic        Start, Cancel;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .MDOp    (MDOp),
        .Start   (Start),
        .Cancel  (Cancel),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: architectural result straight from the arithmetic definitions.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output bit wr);
        longint      sp;
        logic [63:0] up;
        int          ia, ib;
        wr = 1'b1;
        h  = m_hi;
        l  = m_lo;
        ia = a;
        ib = b;
        case (op)
            MDOP_MULT: begin
                sp = longint'(ia) * longint'(ib);
                {h, l} = sp;
            end
            MDOP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                {h, l} = up;
            end
            MDOP_DIV: begin
                if (b == 0) wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 0;
                end else begin
                    l = ia / ib;
                    h = ia % ib;
                end
            end
            MDOP_DIVU: begin
                if (b == 0) wr = 1'b0;
                else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: wr = 1'b0;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int restart_at, input int cancel_at);
        logic [31:0] eh, el;
        bit          wr;
        int          n;
        model(op, a, b, eh, el, wr);
        n = (op == MDOP_MULT || op == MDOP_MULTU) ? 5 : 10;
        MDOp = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = MDOP_NONE; A = $urandom; B = $urandom;
        for (int i = 1; i <= n; i++) begin
            check("busy_run", {31'd0, Busy}, 32'd1);
            check("hold_hi", HI, m_hi);
            check("hold_lo", LO, m_lo);
            if (i == restart_at) begin
                Start = 1'b1;
                MDOp  = 3'($urandom_range(1, 6));
                A = $urandom; B = $urandom;
            end
            if (i == cancel_at) Cancel = 1'b1;
            tick();
            Start = 1'b0; Cancel = 1'b0; MDOp = MDOP_NONE;
            if (i == cancel_at) begin
                check("cancel_busy", {31'd0, Busy}, 32'd0);
                check("cancel_hi", HI, m_hi);
                check("cancel_lo", LO, m_lo);
                $display("op=%0d a=%h b=%h cancelled at cycle %0d hi=%h lo=%h", op, a, b, i, HI, LO);
                return;
            end
        end
        check("busy_done", {31'd0, Busy}, 32'd0);
        if (wr) begin
            m_hi = eh;
            m_lo = el;
        end
        check("res_hi", HI, m_hi);
        check("res_lo", LO, m_lo);
        $display("op=%0d a=%h b=%h hi=%h lo=%h", op, a, b, HI, LO);
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
        MDOp = op; A = a; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = MDOP_NONE;
        if (op == MDOP_MTHI) m_hi = a;
        else m_lo = a;
        check("mt_busy", {31'd0, Busy}, 32'd0);
        check("mt_hi", HI, m_hi);
        check("mt_lo", LO, m_lo);
        $display("op=%0d a=%h hi=%h lo=%h", op, a, HI, LO);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rn, rc;
        reset_n = 1'b0; A = 0; B = 0; MDOp = MDOP_NONE; Start = 1'b0; Cancel = 1'b0;
        m_hi = 0; m_lo = 0;
        tick(); tick();
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset_n = 1'b1;
        tick();

        // Plan 1-3
        run_op(MDOP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
        check("p1_hi", HI, 32'hFFFF_FFFF);
        check("p1_lo", LO, 32'hFFFF_FFFA);
        run_op(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("p2_hi", HI, 32'hFFFF_FFFE);
        check("p2_lo", LO, 32'h0000_0001);
        run_op(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("p3_lo", LO, 32'hFFFF_FFFD);
        check("p3_hi", HI, 32'hFFFF_FFFF);
        run_op(MDOP_DIVU, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("p3u_lo", LO, 32'h7FFF_FFFC);
        check("p3u_hi", HI, 32'd1);

        // Plan 4: divide by zero, then signed overflow
        mt_op(MDOP_MTHI, 32'h11);
        mt_op(MDOP_MTLO, 32'h22);
        run_op(MDOP_DIV, 32'h1234_5678, 32'd0, 0, 0);
        check("p4_hi", HI, 32'h11);
        check("p4_lo", LO, 32'h22);
        run_op(MDOP_DIVU, 32'h1234_5678, 32'd0, 0, 0);
        check("p4u_hi", HI, 32'h11);
        run_op(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("p4o_lo", LO, 32'h8000_0000);
        check("p4o_hi", HI, 32'd0);

        // Plan 5: MTLO, then restart attempt during busy
        mt_op(MDOP_MTLO, 32'hDEAD_BEEF);
        check("p5_lo", LO, 32'hDEAD_BEEF);
        run_op(MDOP_MULT, 32'd7, 32'hFFFF_FFFD, 3, 0);
        check("p5_hi", HI, 32'hFFFF_FFFF);
        check("p5_lo", LO, 32'hFFFF_FFEB);

        // Idle no-ops: NONE, 111, Cancel overriding Start
        MDOp = MDOP_NONE; A = 32'hAAAA_AAAA; Start = 1'b1; tick();
        MDOp = 3'b111; tick();
        MDOp = MDOP_MULT; Cancel = 1'b1; tick();
        MDOp = MDOP_MTHI; tick();
        Start = 1'b0; Cancel = 1'b0; MDOp = MDOP_NONE;
        check("noop_busy", {31'd0, Busy}, 32'd0);
        check("noop_hi", HI, m_hi);
        check("noop_lo", LO, m_lo);
        tick();
        check("noop_busy2", {31'd0, Busy}, 32'd0);

        // Plan 6: cancel on the last busy cycle, then async reset mid-divide
        run_op(MDOP_MULT, 32'h0001_0000, 32'h0001_0000, 0, 5);
        MDOp = MDOP_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = MDOP_NONE;
        tick(); tick();
        check("p6_busy_pre", {31'd0, Busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("p6_busy", {31'd0, Busy}, 32'd0);
        check("p6_hi", HI, 32'd0);
        check("p6_lo", LO, 32'd0);
        m_hi = 0; m_lo = 0;
        tick();
        reset_n = 1'b1;
        tick();
        check("p6_idle", {31'd0, Busy}, 32'd0);

        // Randomized ops
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (rop == MDOP_MTHI || rop == MDOP_MTLO) begin
                mt_op(rop, ra);
            end else begin
                rn = (rop == MDOP_MULT || rop == MDOP_MULTU) ? 5 : 10;
                rc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rn) : 0;
                run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, rn) : 0, rc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline, in parallel with the ALU.
- Takes the same forwarded A/B operands as the ALU and holds architectural HI/LO.
- Emulates multi-cycle mult/div latency with a busy counter.
- Its HI/LO outputs feed the EX result mux (mfhi/mflo) alongside the ALU Result; Busy feeds the hazard unit.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- MDOp  in  3  operation: NONE=000, MULT=001, MULTU=010, DIV=011, DIVU=100, MTHI=101, MTLO=110; 111 behaves as NONE.
- Start  in  1  EX instruction is a valid mult/div/mt op this cycle (deasserted on bubbles).
- Cancel  in  1  exception flush; aborts any in-flight op.
- Busy  out  1  operation in progress.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset_n=0, asynchronous): HI=0, LO=0, Busy=0, counter=0, state IDLE. Reset mid-operation discards the pending result.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1; counter counts down from N to 1.
- IDLE with Start=1 at edge t and MDOp a mult/div op:
  - Compute the 64-bit result from A/B sampled at t; latch it into internal temp_hi/temp_lo.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - Busy is high for cycles t+1 … t+N.
  - At the edge ending cycle t+N: HI/LO ← temp; state → IDLE.
  - New HI/LO are visible in cycle t+N+1 with Busy=0.
- MULT: {HI,LO} = signed(A) × signed(B), full 64-bit product. MULTU: unsigned.
- DIV: LO = signed(A)/signed(B), HI = signed(A)%signed(B), truncation toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, remainder in HI.
- Divide by zero (B=0, DIV or DIVU): runs the full DIV_CYCLES with Busy; HI/LO unchanged at completion.
- MTHI/MTLO with Start=1 in IDLE: HI (or LO) ← A at that edge. Busy is not asserted; the new value is visible the next cycle.
- Start while Busy=1: ignored; the hazard unit guarantees a stall. The bench checks that no state changes.
- Start with MDOp=NONE/111: no effect.
- Cancel=1:
  - In RUN: counter→0, state→IDLE at that edge, temp discarded, HI/LO retained.
  - In IDLE: Cancel overrides Start for that edge; nothing happens.
- Cancel on the final RUN cycle (counter=1): Cancel wins; no HI/LO write.
- HI/LO/Busy are registered outputs only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package mips_defs holds the MDOp encodings (MDOP_NONE … MDOP_MTLO) and the default latency constants. The hazard unit and decoder reuse them.
- Optional sub-module mdu_core: combinational 64-bit mult/div datapath, including the div-by-zero flag. The top level keeps the FSM, counter and HI/LO registers.

Test Plan:
1. Reset, then Start MULT with A=0xFFFFFFFE (−2), B=3 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
3. DIV A=−7 (0xFFFFFFF9), B=2 → Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands → LO=0x7FFFFFFC, HI=1.
4. With HI/LO=0x11/0x22, DIV B=0 → Busy 10 cycles, HI/LO still 0x11/0x22. Then DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
5. MTLO A=0xDEADBEEF → LO=0xDEADBEEF next cycle, Busy never high. Then MULT started with Start pulsed again at Busy cycle 3 with different operands → second Start ignored; result matches the first op only.
6. MULT in flight with Cancel at Busy cycle 5 (last) → Busy falls, HI/LO unchanged. Then a DIV with reset_n pulsed low mid-run → HI=LO=0 and Busy=0 immediately, asynchronously.
